// File: rtl/pin_output_stage_pkg.sv
// Shared types and width helpers for the pin output stage.
// Used by the top level and the per-pin slice.
package p1v_pin_pkg;

    typedef enum logic [1:0] {
        HIZ,
        TURN,
        DRIVE
    } pin_state_t;

    localparam int READBACK_LATENCY = 5;

    function automatic int cnt_w(input int n);
        return ($clog2(n + 1) < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/pin_output_stage_if.sv
// Core-facing and pad-facing pin vectors of the output stage.
// master = core/pad side, slave = the output stage.
interface pin_output_stage_if #(
    parameter int NUM_PINS = 32
);

    logic [NUM_PINS-1:0] pin_out;
    logic [NUM_PINS-1:0] pin_dir;
    logic [NUM_PINS-1:0] pin_sync;
    logic [NUM_PINS-1:0] fault_clr;
    logic [NUM_PINS-1:0] o;
    logic [NUM_PINS-1:0] oe;
    logic [NUM_PINS-1:0] turn_busy;
    logic [NUM_PINS-1:0] fault;

    modport master (
        output pin_out, pin_dir, pin_sync, fault_clr,
        input  o, oe, turn_busy, fault
    );

    modport slave (
        input  pin_out, pin_dir, pin_sync, fault_clr,
        output o, oe, turn_busy, fault
    );

endinterface

// File: rtl/pin_output_stage_slice.sv
// Single-pin turnaround FSM and drive-fault detector.
// oe/turn_busy/fault are all registered.
module pin_output_slice
    import p1v_pin_pkg::*;
#(
    parameter int TURNAROUND   = 2,
    parameter int FAULT_CYCLES = 8
) (
    input  logic clock_80,
    input  logic res,
    input  logic pdir,
    input  logic o,
    input  logic pin_sync,
    input  logic fault_clr,
    output logic oe,
    output logic turn_busy,
    output logic fault
);

    localparam int CW = cnt_w(TURNAROUND);
    localparam int MW = cnt_w(FAULT_CYCLES);
    localparam logic [CW-1:0] CNT_LOAD =
        CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
    localparam logic [MW-1:0] MSAT = MW'(FAULT_CYCLES);
    localparam logic [MW-1:0] MLAST = MW'(FAULT_CYCLES - 1);

    pin_state_t    state;
    logic [CW-1:0] cnt;
    logic [MW-1:0] mcnt;
    logic          o_last;
    logic          mism;

    always_ff @(posedge clock_80 or posedge res) begin
        if (res) begin
            state     <= HIZ;
            cnt       <= '0;
            oe        <= 1'b0;
            turn_busy <= 1'b0;
        end else begin
            unique case (state)
                HIZ: begin
                    if (pdir) begin
                        if (TURNAROUND > 0) begin
                            state     <= TURN;
                            cnt       <= CNT_LOAD;
                            turn_busy <= 1'b1;
                            oe        <= 1'b0;
                        end else begin
                            state <= DRIVE;
                            oe    <= 1'b1;
                        end
                    end
                end
                TURN: begin
                    if (!pdir) begin
                        state     <= HIZ;
                        cnt       <= '0;
                        turn_busy <= 1'b0;
                    end else if (cnt == '0) begin
                        state     <= DRIVE;
                        oe        <= 1'b1;
                        turn_busy <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DRIVE: begin
                    // release is immediate, no Hi-Z gap needed
                    if (!pdir) begin
                        state <= HIZ;
                        oe    <= 1'b0;
                    end
                end
                default: begin
                    state     <= HIZ;
                    oe        <= 1'b0;
                    turn_busy <= 1'b0;
                end
            endcase
        end
    end

    // only a stable driven value may be blamed on the pad
    assign mism = oe && (o == o_last) && (pin_sync != o);

    always_ff @(posedge clock_80 or posedge res) begin
        if (res) begin
            mcnt   <= '0;
            fault  <= 1'b0;
            o_last <= 1'b0;
        end else begin
            o_last <= o;
            if (fault_clr) begin
                mcnt  <= '0;
                fault <= 1'b0;
            end else if (!mism) begin
                mcnt <= '0;
            end else if (mcnt != MSAT) begin
                mcnt <= mcnt + 1'b1;
                if (mcnt == MLAST) fault <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/pin_output_stage.sv
// Pad output stage: matched out/dir pipeline, o register,
// and one turnaround/fault slice per pin.
module pin_output_stage
    import p1v_pin_pkg::*;
#(
    parameter int NUM_PINS        = 32,
    parameter int PIPELINE_STAGES = 2,
    parameter int TURNAROUND      = 2,
    parameter int FAULT_CYCLES    = 8
) (
    input logic          clock_80,
    input logic          res,
    pin_output_stage_if.slave bus
);

    logic [NUM_PINS-1:0] pout_q [PIPELINE_STAGES];
    logic [NUM_PINS-1:0] pdir_q [PIPELINE_STAGES];
    logic [NUM_PINS-1:0] pout_p;
    logic [NUM_PINS-1:0] pdir_p;
    logic [NUM_PINS-1:0] o_q;
    logic [NUM_PINS-1:0] oe_w;
    logic [NUM_PINS-1:0] busy_w;
    logic [NUM_PINS-1:0] fault_w;

    // data and dir share one delay so o and oe stay aligned
    always_ff @(posedge clock_80 or posedge res) begin
        if (res) begin
            for (int s = 0; s < PIPELINE_STAGES; s++) begin
                pout_q[s] <= '0;
                pdir_q[s] <= '0;
            end
            o_q <= '0;
        end else begin
            pout_q[0] <= bus.pin_out;
            pdir_q[0] <= bus.pin_dir;
            for (int s = 1; s < PIPELINE_STAGES; s++) begin
                pout_q[s] <= pout_q[s-1];
                pdir_q[s] <= pdir_q[s-1];
            end
            o_q <= pout_p;
        end
    end

    assign pout_p = pout_q[PIPELINE_STAGES-1];
    assign pdir_p = pdir_q[PIPELINE_STAGES-1];

    for (genvar i = 0; i < NUM_PINS; i++) begin : g_pin
        pin_output_slice #(
            .TURNAROUND   (TURNAROUND),
            .FAULT_CYCLES (FAULT_CYCLES)
        ) u_slice (
            .clock_80  (clock_80),
            .res       (res),
            .pdir      (pdir_p[i]),
            .o         (o_q[i]),
            .pin_sync  (bus.pin_sync[i]),
            .fault_clr (bus.fault_clr[i]),
            .oe        (oe_w[i]),
            .turn_busy (busy_w[i]),
            .fault     (fault_w[i])
        );
    end

    assign bus.o         = o_q;
    assign bus.oe        = oe_w;
    assign bus.turn_busy = busy_w;
    assign bus.fault     = fault_w;

endmodule
